// File: rtl/dii_pkg.sv
// Shared DII types for the debug-interconnect blocks: flit layout, arbiter
// states and the index-width helper used by the arbiter and its selector.
package dii_pkg;

   localparam int DII_DW = 16;

   typedef struct packed {
      logic [DII_DW-1:0] data;
      logic              first;
      logic              last;
   } dii_flit_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // An index into N channels needs at least one bit, even when N=1.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dii_rr_select.sv
// Combinational round-robin candidate search: the first set request at or
// after ptr, wrapping modulo N, found by scanning a doubled request vector.
module dii_rr_select
   import dii_pkg::*;
#(
   parameter int N = 2,
   localparam int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [2*N-1:0] w_dbl;

   assign w_dbl = {req, req};

   always_comb begin
      int base;
      found = 1'b0;
      idx   = '0;
      base  = int'(ptr) % N;
      // Scan from the far end so the request nearest to ptr overrides.
      for (int k = N - 1; k >= 0; k--) begin
         if (w_dbl[base + k]) begin
            found = 1'b1;
            idx   = IW'((base + k) % N);
         end
      end
   end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-atomic round-robin merge of N DII egress channels onto one port,
// with a registered output stage that isolates ring-side timing.
module dii_packet_arbiter
   import dii_pkg::*;
#(
   parameter int N  = 2,
   parameter int DW = DII_DW,
   localparam int IW = idx_width(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*DW-1:0] in_data,
   input  logic [N-1:0]    in_first,
   input  logic [N-1:0]    in_last,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   output logic [DW-1:0]   out_data,
   output logic            out_first,
   output logic            out_last,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            grant_valid,
   output logic [IW-1:0]   grant_idx
);

   arb_state_t    r_state;
   arb_state_t    w_state_next;
   logic [IW-1:0] r_rr_ptr;
   logic [IW-1:0] w_rr_ptr_next;
   logic [IW-1:0] r_grant_idx;
   logic [IW-1:0] w_grant_idx_next;

   logic [DW-1:0] r_out_data;
   logic          r_out_first;
   logic          r_out_last;
   logic          r_out_valid;

   logic [N-1:0]  w_gnt_onehot;
   logic [DW-1:0] w_sel_data;
   logic          w_sel_first;
   logic          w_sel_last;
   logic          w_sel_valid;
   logic          w_can_load;
   logic          w_xfer;
   logic          w_cand_found;
   logic [IW-1:0] w_cand_idx;

   dii_rr_select #(
      .N (N)
   ) u_rr_select (
      .req   (in_valid),
      .ptr   (r_rr_ptr),
      .found (w_cand_found),
      .idx   (w_cand_idx)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_onehot
         assign w_gnt_onehot[gi] = (r_grant_idx == IW'(gi));
      end
   endgenerate

   always_comb begin
      w_sel_data  = '0;
      w_sel_first = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (w_gnt_onehot[i]) begin
            w_sel_data  = in_data[i*DW +: DW];
            w_sel_first = in_first[i];
            w_sel_last  = in_last[i];
            w_sel_valid = in_valid[i];
         end
      end
   end

   // The output slot can take a flit when empty or draining this cycle.
   assign w_can_load = (r_state == LOCKED) && (!r_out_valid || out_ready);
   assign in_ready   = w_gnt_onehot & {N{w_can_load}};
   assign w_xfer     = w_can_load && w_sel_valid;

   always_comb begin
      w_state_next     = r_state;
      w_rr_ptr_next    = r_rr_ptr;
      w_grant_idx_next = r_grant_idx;
      case (r_state)
         IDLE: begin
            if (w_cand_found) begin
               w_state_next     = LOCKED;
               w_grant_idx_next = w_cand_idx;
            end
         end
         LOCKED: begin
            if (w_xfer && w_sel_last) begin
               w_state_next  = IDLE;
               w_rr_ptr_next = (r_grant_idx == IW'(N - 1)) ? '0 : r_grant_idx + 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_grant_idx <= '0;
      end else begin
         r_state     <= w_state_next;
         r_rr_ptr    <= w_rr_ptr_next;
         r_grant_idx <= w_grant_idx_next;
      end
   end

   // A load in the same cycle as a drain simply replaces the old flit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_first <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_xfer) begin
         r_out_data  <= w_sel_data;
         r_out_first <= w_sel_first;
         r_out_last  <= w_sel_last;
         r_out_valid <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_data    = r_out_data;
   assign out_first   = r_out_first;
   assign out_last    = r_out_last;
   assign out_valid   = r_out_valid;
   assign grant_valid = (r_state == LOCKED);
   assign grant_idx   = r_grant_idx;

`ifndef SYNTHESIS
   a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
      $onehot0(in_ready));

   a_out_stable: assert property (@(posedge clk) disable iff (rst)
      (r_out_valid && !out_ready) |=>
         (out_valid && $stable(out_data) && $stable(out_first) && $stable(out_last)));
`endif

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Directed bench for dii_packet_arbiter (N=2, DW=16): per-channel flit queues
// feed the inputs, delivered output flits are logged with their cycle number.
module tb_dii_packet_arbiter;

   localparam int N  = 2;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_first;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [DW-1:0]   out_data;
   logic            out_first;
   logic            out_last;
   logic            out_valid;
   logic            out_ready;
   logic            grant_valid;
   logic [0:0]      grant_idx;

   always #5 clk = ~clk;

   dii_packet_arbiter #(
      .N  (N),
      .DW (DW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_first    (in_first),
      .in_last     (in_last),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_first   (out_first),
      .out_last    (out_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;

   logic [17:0] q0[$];
   logic [17:0] q1[$];
   int hold_lo, hold_hi, stall_lo, stall_hi;

   logic [15:0] log_data[$];
   logic [1:0]  log_fl[$];
   int          log_cyc[$];

   logic [15:0] e3_data[8] = '{16'hA001, 16'hA002, 16'hB001, 16'hB002,
                               16'hA003, 16'hA004, 16'hB003, 16'hB004};
   int          e3_cyc[8]  = '{2, 3, 5, 6, 8, 9, 11, 12};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [17:0] flit(input logic [15:0] d, input logic f, input logic l);
      return {d, f, l};
   endfunction

   task automatic drive();
      logic [17:0] h0;
      logic [17:0] h1;
      h0 = (q0.size() > 0) ? q0[0] : 18'h0;
      h1 = (q1.size() > 0) ? q1[0] : 18'h0;
      in_valid[0] = (q0.size() > 0) && !(cyc >= hold_lo && cyc <= hold_hi);
      in_valid[1] = (q1.size() > 0);
      in_data     = {h1[17:2], h0[17:2]};
      in_first    = {h1[1], h0[1]};
      in_last     = {h1[0], h0[0]};
      out_ready   = !(cyc >= stall_lo && cyc <= stall_hi);
   endtask

   task automatic tick();
      logic f0, f1, fo;
      @(negedge clk);
      f0 = in_valid[0] && in_ready[0] && !rst;
      f1 = in_valid[1] && in_ready[1] && !rst;
      fo = out_valid && out_ready && !rst;
      if (fo) begin
         log_data.push_back(out_data);
         log_fl.push_back({out_first, out_last});
         log_cyc.push_back(cyc);
         $display("[TB] cycle %0d out data=0x%h first=%0b last=%0b", cyc, out_data, out_first, out_last);
      end
      @(posedge clk);
      #1;
      if (f0 && q0.size() > 0) void'(q0.pop_front());
      if (f1 && q1.size() > 0) void'(q1.pop_front());
      cyc++;
      drive();
      #1;
   endtask

   task automatic clear_log();
      log_data.delete();
      log_fl.delete();
      log_cyc.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q0.delete();
      q1.delete();
      hold_lo  = -1;
      hold_hi  = -2;
      stall_lo = -1;
      stall_hi = -2;
      cyc      = -10;
      drive();
      tick();
      tick();
      rst = 1'b0;
      clear_log();
      cyc = 0;
   endtask

   task automatic start();
      drive();
      #1;
   endtask

   task automatic check_out(input string tag, input int i, input logic [15:0] d,
                            input int c, input logic f, input logic l);
      if (i < log_data.size()) begin
         check({tag, "_data"}, log_data[i], d);
         check({tag, "_cycle"}, log_cyc[i], c);
         check({tag, "_fl"}, log_fl[i], {f, l});
      end else begin
         check({tag, "_missing"}, log_data.size(), i + 1);
      end
   endtask

   initial begin
      // Reset, then idle with nothing requesting.
      do_reset();
      start();
      check("rst_out_data", out_data, 0);
      check("rst_out_fl", {out_first, out_last}, 0);
      check("rst_grant_idx", grant_idx, 0);
      for (int i = 0; i < 20; i++) begin
         check("idle_out_valid", out_valid, 0);
         check("idle_in_ready", in_ready, 0);
         check("idle_grant_valid", grant_valid, 0);
         tick();
      end

      // Single 3-flit packet on channel 1.
      do_reset();
      q1.push_back(flit(16'h1111, 1'b1, 1'b0));
      q1.push_back(flit(16'h2222, 1'b0, 1'b0));
      q1.push_back(flit(16'h3333, 1'b0, 1'b1));
      start();
      check("t2_bubble_ready", in_ready, 0);
      check("t2_bubble_gv", grant_valid, 0);
      tick();
      check("t2_gv", grant_valid, 1);
      check("t2_gidx", grant_idx, 1);
      check("t2_ready", in_ready, 2'b10);
      check("t2_out_valid", out_valid, 0);
      repeat (6) tick();
      check("t2_count", log_data.size(), 3);
      check_out("t2_f0", 0, 16'h1111, 2, 1'b1, 1'b0);
      check_out("t2_f1", 1, 16'h2222, 3, 1'b0, 1'b0);
      check_out("t2_f2", 2, 16'h3333, 4, 1'b0, 1'b1);

      // Pointer returned to 0: with both requesting, channel 0 wins first.
      clear_log();
      cyc = 0;
      q0.push_back(flit(16'h4444, 1'b1, 1'b1));
      q1.push_back(flit(16'h5555, 1'b1, 1'b1));
      start();
      check("t2b_c0_gv", grant_valid, 0);
      tick();
      check("t2b_c1_gidx", grant_idx, 0);
      check("t2b_c1_ready", in_ready, 2'b01);
      tick();
      check("t2b_c2_gv", grant_valid, 0);
      tick();
      check("t2b_c3_gidx", grant_idx, 1);
      repeat (4) tick();
      check("t2b_count", log_data.size(), 2);
      check_out("t2b_p0", 0, 16'h4444, 2, 1'b1, 1'b1);
      check_out("t2b_p1", 1, 16'h5555, 4, 1'b1, 1'b1);

      // Both channels streaming 2-flit packets: strict alternation.
      do_reset();
      for (int p = 0; p < 2; p++) begin
         q0.push_back(flit(16'hA001 + 16'(2*p), 1'b1, 1'b0));
         q0.push_back(flit(16'hA002 + 16'(2*p), 1'b0, 1'b1));
         q1.push_back(flit(16'hB001 + 16'(2*p), 1'b1, 1'b0));
         q1.push_back(flit(16'hB002 + 16'(2*p), 1'b0, 1'b1));
      end
      start();
      repeat (15) tick();
      check("t3_count", log_data.size(), 8);
      for (int i = 0; i < 8; i++) begin
         check_out($sformatf("t3_f%0d", i), i, e3_data[i], e3_cyc[i], (i % 2) == 0, (i % 2) == 1);
      end

      // Downstream stall after the first flit of a 4-flit packet.
      do_reset();
      q0.push_back(flit(16'hC001, 1'b1, 1'b0));
      q0.push_back(flit(16'hC002, 1'b0, 1'b0));
      q0.push_back(flit(16'hC003, 1'b0, 1'b0));
      q0.push_back(flit(16'hC004, 1'b0, 1'b1));
      stall_lo = 2;
      stall_hi = 6;
      start();
      for (int k = 0; k < 12; k++) begin
         if (k >= 2 && k <= 6) begin
            check("t4_stall_valid", out_valid, 1);
            check("t4_stall_data", out_data, 16'hC001);
            check("t4_stall_ready", in_ready, 0);
         end
         tick();
      end
      check("t4_count", log_data.size(), 4);
      check_out("t4_f0", 0, 16'hC001, 7, 1'b1, 1'b0);
      check_out("t4_f1", 1, 16'hC002, 8, 1'b0, 1'b0);
      check_out("t4_f2", 2, 16'hC003, 9, 1'b0, 1'b0);
      check_out("t4_f3", 3, 16'hC004, 10, 1'b0, 1'b1);

      // Channel 0 pauses mid-packet; channel 1 must wait for its last flit.
      do_reset();
      q0.push_back(flit(16'hD001, 1'b1, 1'b0));
      q0.push_back(flit(16'hD002, 1'b0, 1'b0));
      q0.push_back(flit(16'hD003, 1'b0, 1'b0));
      q0.push_back(flit(16'hD004, 1'b0, 1'b1));
      q1.push_back(flit(16'hE001, 1'b1, 1'b0));
      q1.push_back(flit(16'hE002, 1'b0, 1'b1));
      hold_lo = 3;
      hold_hi = 5;
      start();
      for (int k = 0; k < 14; k++) begin
         if (k <= 8) check("t5_ch1_ready", in_ready[1], 0);
         if (k >= 1 && k <= 7) begin
            check("t5_gv", grant_valid, 1);
            check("t5_gidx", grant_idx, 0);
         end
         if (k == 9) check("t5_ch1_granted", in_ready, 2'b10);
         tick();
      end
      check("t5_count", log_data.size(), 6);
      check_out("t5_d0", 0, 16'hD001, 2, 1'b1, 1'b0);
      check_out("t5_d1", 1, 16'hD002, 3, 1'b0, 1'b0);
      check_out("t5_d2", 2, 16'hD003, 7, 1'b0, 1'b0);
      check_out("t5_d3", 3, 16'hD004, 8, 1'b0, 1'b1);
      check_out("t5_e0", 4, 16'hE001, 10, 1'b1, 1'b0);
      check_out("t5_e1", 5, 16'hE002, 11, 1'b0, 1'b1);

      // Reset in the middle of a channel-0 packet, then channel 1 requests.
      do_reset();
      q0.push_back(flit(16'hF001, 1'b1, 1'b0));
      q0.push_back(flit(16'hF002, 1'b0, 1'b0));
      q0.push_back(flit(16'hF003, 1'b0, 1'b0));
      q0.push_back(flit(16'hF004, 1'b0, 1'b1));
      start();
      for (int k = 0; k < 12; k++) begin
         if (k == 3) begin
            rst = 1'b1;
            q0.delete();
            drive();
            #1;
         end
         if (k == 4) begin
            check("t6_out_valid", out_valid, 0);
            check("t6_out_data", out_data, 0);
            check("t6_out_fl", {out_first, out_last}, 0);
            check("t6_in_ready", in_ready, 0);
            check("t6_gv", grant_valid, 0);
            check("t6_gidx", grant_idx, 0);
            rst = 1'b0;
            clear_log();
            q1.push_back(flit(16'h6001, 1'b1, 1'b0));
            q1.push_back(flit(16'h6002, 1'b0, 1'b1));
            drive();
            #1;
         end
         if (k == 5) check("t6_new_gidx", grant_idx, 1);
         tick();
      end
      check("t6_count", log_data.size(), 2);
      check_out("t6_g0", 0, 16'h6001, 6, 1'b1, 1'b0);
      check_out("t6_g1", 1, 16'h6002, 7, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
